// File: rtl/instr_fetch_unit.sv
// Fetch-side responder: issues one req/ack transaction per PC, drops stale
// responses after a redirect and parks a response in a skid register while decode stalls.
//
// state   | meaning
// IDLE    | no request outstanding; issue mem_req for PCF unless redirected
// WAIT    | request outstanding, response wanted
// SKID    | response parked in skid, waiting for decode to free up
// DISCARD | request outstanding but stale; swallow the response
module instr_fetch_unit #(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] PCF,
  input  logic              FlushF,
  input  logic              StallD,
  output logic [DATA_W-1:0] InstrF,
  output logic              InstrValidF,
  output logic              FetchStallF,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WAIT    = 2'd1;
  localparam logic [1:0] SKID    = 2'd2;
  localparam logic [1:0] DISCARD = 2'd3;

  logic [1:0]        state;
  logic [DATA_W-1:0] skid;
  logic              ack_ok;
  logic              take_rsp;

  // An ack with no request outstanding (e.g. a late reply after reset) is ignored.
  assign ack_ok   = mem_ack && mem_req;
  assign take_rsp = (state == WAIT) && ack_ok;

  assign FetchStallF = !FlushF && !take_rsp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      skid     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!FlushF) begin
            mem_req  <= 1'b1;
            mem_addr <= PCF;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (ack_ok) begin
            mem_req <= 1'b0;
            if (FlushF) begin
              state <= IDLE;
            end else if (StallD) begin
              skid  <= mem_rdata;
              state <= SKID;
            end else begin
              state <= IDLE;
            end
          end else if (FlushF) begin
            state <= DISCARD;
          end
        end
        SKID: begin
          if (FlushF || !StallD) state <= IDLE;
        end
        DISCARD: begin
          if (ack_ok) begin
            mem_req <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Flush wins over StallD; a stalled decode keeps InstrF/InstrValidF frozen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      InstrF      <= NOP_INSTR;
      InstrValidF <= 1'b0;
    end else if (FlushF) begin
      InstrF      <= NOP_INSTR;
      InstrValidF <= 1'b0;
    end else if (!StallD) begin
      if (take_rsp) begin
        InstrF      <= mem_rdata;
        InstrValidF <= 1'b1;
      end else if (state == SKID) begin
        InstrF      <= skid;
        InstrValidF <= 1'b1;
      end else begin
        InstrF      <= NOP_INSTR;
        InstrValidF <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a transaction-level model checked every
// cycle, plus hand-computed literal checks along the directed sequence.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] PCF = '0;
  logic        FlushF = 1'b0;
  logic        StallD = 1'b0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] InstrF;
  logic        InstrValidF;
  logic        FetchStallF;
  logic        mem_req;
  logic [31:0] mem_addr;

  int tests = 0;
  int fails = 0;

  instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .PCF(PCF), .FlushF(FlushF), .StallD(StallD),
    .InstrF(InstrF), .InstrValidF(InstrValidF), .FetchStallF(FetchStallF),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Model: one outstanding request (maybe stale), an optional parked word, the IF/ID word.
  typedef struct packed {
    logic        pend;
    logic        stale;
    logic        sfull;
    logic [31:0] skid;
    logic [31:0] addr;
    logic [31:0] instr;
    logic        valid;
  } model_t;

  localparam model_t MODEL_RST = '{pend: 1'b0, stale: 1'b0, sfull: 1'b0, skid: 32'h0,
                                   addr: 32'h0, instr: NOP, valid: 1'b0};
  model_t mdl = MODEL_RST;

  function automatic model_t step(model_t m, logic [31:0] pc, logic fl, logic sd,
                                  logic ak, logic [31:0] rd);
    model_t      n = m;
    logic        got = 1'b0;
    logic [31:0] word = NOP;
    if (fl) begin
      n.sfull = 1'b0;
      if (m.pend && ak) begin
        n.pend  = 1'b0;
        n.stale = 1'b0;
      end else if (m.pend) begin
        n.stale = 1'b1;
      end
      n.instr = NOP;
      n.valid = 1'b0;
    end else begin
      if (m.pend) begin
        if (ak) begin
          n.pend  = 1'b0;
          n.stale = 1'b0;
          if (!m.stale) begin
            if (sd) begin
              n.sfull = 1'b1;
              n.skid  = rd;
            end else begin
              got  = 1'b1;
              word = rd;
            end
          end
        end
      end else if (m.sfull) begin
        if (!sd) begin
          got     = 1'b1;
          word    = m.skid;
          n.sfull = 1'b0;
        end
      end else begin
        n.pend = 1'b1;
        n.addr = pc;
      end
      if (!sd) begin
        n.instr = word;
        n.valid = got;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) mdl <= MODEL_RST;
    else     mdl <= step(mdl, PCF, FlushF, StallD, mem_ack, mem_rdata);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always begin
    @(negedge clk);
    #2;
    chk("mdl_mem_req", {31'b0, mem_req}, {31'b0, mdl.pend});
    chk("mdl_mem_addr", mem_addr, mdl.addr);
    chk("mdl_instr", InstrF, mdl.instr);
    chk("mdl_valid", {31'b0, InstrValidF}, {31'b0, mdl.valid});
    chk("mdl_stall", {31'b0, FetchStallF},
        {31'b0, !FlushF && !(mdl.pend && !mdl.stale && mem_ack)});
  end

  task automatic cyc(input logic [31:0] pc, input logic fl, input logic sd,
                     input logic ak, input logic [31:0] rd);
    @(negedge clk);
    PCF = pc; FlushF = fl; StallD = sd; mem_ack = ak; mem_rdata = rd;
    #3;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #3;
    chk("rst_req", {31'b0, mem_req}, 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_instr", InstrF, NOP);
    chk("rst_valid", {31'b0, InstrValidF}, 32'd0);

    // zero-wait memory, PCF 0,4,8
    @(negedge clk);
    rst = 1'b0;
    #3;
    chk("zw_idle_stall", {31'b0, FetchStallF}, 32'd1);
    cyc(32'h0, 0, 0, 1, 32'hA000_0000);
    chk("zw_req0", {31'b0, mem_req}, 32'd1);
    chk("zw_addr0", mem_addr, 32'h0);
    chk("zw_ack_stall", {31'b0, FetchStallF}, 32'd0);
    cyc(32'h4, 0, 0, 0, 32'h0);
    chk("zw_instr0", InstrF, 32'hA000_0000);
    chk("zw_valid0", {31'b0, InstrValidF}, 32'd1);
    cyc(32'h4, 0, 0, 1, 32'hA000_0004);
    chk("zw_addr4", mem_addr, 32'h4);
    chk("zw_valid_gap", {31'b0, InstrValidF}, 32'd0);
    cyc(32'h8, 0, 0, 0, 32'h0);
    chk("zw_instr4", InstrF, 32'hA000_0004);
    cyc(32'h8, 0, 0, 1, 32'hA000_0008);
    chk("zw_addr8", mem_addr, 32'h8);

    // 3-cycle latency at 0x10
    cyc(32'h10, 0, 0, 0, 32'h0);
    chk("zw_instr8", InstrF, 32'hA000_0008);
    cyc(32'h10, 0, 0, 0, 32'h0);
    chk("lat_stall1", {31'b0, FetchStallF}, 32'd1);
    chk("lat_addr1", mem_addr, 32'h10);
    cyc(32'h10, 0, 0, 0, 32'h0);
    chk("lat_stall2", {31'b0, FetchStallF}, 32'd1);
    chk("lat_req2", {31'b0, mem_req}, 32'd1);
    cyc(32'h10, 0, 0, 1, 32'hB000_0010);
    chk("lat_ack_stall", {31'b0, FetchStallF}, 32'd0);
    cyc(32'h14, 0, 0, 0, 32'h0);
    chk("lat_instr", InstrF, 32'hB000_0010);

    // flush in WAIT -> stale response discarded, redirect to 0x40
    cyc(32'h14, 1, 0, 0, 32'h0);
    chk("fl_stall", {31'b0, FetchStallF}, 32'd0);
    cyc(32'h40, 0, 0, 0, 32'h0);
    chk("fl_disc_stall", {31'b0, FetchStallF}, 32'd1);
    chk("fl_disc_addr", mem_addr, 32'h14);
    chk("fl_valid", {31'b0, InstrValidF}, 32'd0);
    cyc(32'h40, 0, 0, 1, 32'hBAD0_0001);
    chk("fl_disc_ack_stall", {31'b0, FetchStallF}, 32'd1);
    cyc(32'h40, 0, 0, 0, 32'h0);
    chk("fl_drop_instr", InstrF, NOP);
    chk("fl_drop_valid", {31'b0, InstrValidF}, 32'd0);
    chk("fl_req_low", {31'b0, mem_req}, 32'd0);
    cyc(32'h40, 0, 0, 0, 32'h0);
    chk("fl_new_addr", mem_addr, 32'h40);

    // StallD at ack -> skid holds 0xDEAD for 2 cycles
    cyc(32'h40, 0, 1, 1, 32'h0000_DEAD);
    cyc(32'h44, 0, 1, 0, 32'h0);
    chk("sk_stall1", {31'b0, FetchStallF}, 32'd1);
    chk("sk_hold1", InstrF, NOP);
    cyc(32'h44, 0, 1, 0, 32'h0);
    chk("sk_hold2", InstrF, NOP);
    chk("sk_hold_valid", {31'b0, InstrValidF}, 32'd0);
    cyc(32'h44, 0, 0, 0, 32'h0);
    chk("sk_release_stall", {31'b0, FetchStallF}, 32'd1);
    cyc(32'h44, 0, 1, 0, 32'h0);
    chk("sk_instr", InstrF, 32'h0000_DEAD);
    chk("sk_valid", {31'b0, InstrValidF}, 32'd1);

    // flush + StallD in SKID -> skid dropped
    cyc(32'h44, 0, 1, 1, 32'h0000_BEEF);
    cyc(32'h44, 1, 1, 0, 32'h0);
    chk("skfl_held", InstrF, 32'h0000_DEAD);
    chk("skfl_stall", {31'b0, FetchStallF}, 32'd0);
    cyc(32'h80, 0, 0, 0, 32'h0);
    chk("skfl_instr", InstrF, NOP);
    chk("skfl_valid", {31'b0, InstrValidF}, 32'd0);
    chk("skfl_idle_req", {31'b0, mem_req}, 32'd0);
    cyc(32'h80, 0, 0, 0, 32'h0);
    chk("skfl_no_beef", InstrF, NOP);
    chk("skfl_addr", mem_addr, 32'h80);

    // reset mid-WAIT, then stray ack
    @(negedge clk);
    rst = 1'b1;
    #3;
    chk("mr_req", {31'b0, mem_req}, 32'd0);
    chk("mr_addr", mem_addr, 32'h0);
    chk("mr_instr", InstrF, NOP);
    @(negedge clk);
    rst = 1'b0; PCF = 32'h100; mem_ack = 1'b1; mem_rdata = 32'hBAD0_0002;
    #3;
    chk("mr_stray_stall", {31'b0, FetchStallF}, 32'd1);
    cyc(32'h100, 0, 0, 0, 32'h0);
    chk("mr_new_req", {31'b0, mem_req}, 32'd1);
    chk("mr_new_addr", mem_addr, 32'h100);
    chk("mr_valid", {31'b0, InstrValidF}, 32'd0);
    cyc(32'h100, 0, 0, 1, 32'h0000_C0DE);
    cyc(32'h104, 0, 0, 0, 32'h0);
    chk("mr_instr_after", InstrF, 32'h0000_C0DE);

    // flush coincident with ack, then flush in IDLE
    cyc(32'h104, 1, 0, 1, 32'hBAD0_0003);
    cyc(32'h200, 1, 0, 0, 32'h0);
    chk("fa_req_low", {31'b0, mem_req}, 32'd0);
    chk("fa_instr", InstrF, NOP);
    cyc(32'h200, 0, 0, 0, 32'h0);
    chk("fi_no_req", {31'b0, mem_req}, 32'd0);
    cyc(32'h200, 0, 0, 1, 32'h0000_0011);
    chk("fi_addr", mem_addr, 32'h200);
    cyc(32'h204, 0, 0, 0, 32'h0);
    chk("fi_instr", InstrF, 32'h0000_0011);
    cyc(32'h204, 0, 0, 0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Responder side of the fetch-address interface. Takes the fetch PC from the PC generator, runs a req/ack transaction to a variable-latency instruction memory, and delivers the instruction to the IF/ID boundary. It generates the fetch stall that freezes the PC while memory is busy, and discards stale responses on a branch/jump redirect. A one-entry skid register absorbs a response that arrives while decode is stalled.

Parameters:
ADDR_W, 32, width of PC and memory address
DATA_W, 32, instruction width
NOP_INSTR, 32'h00000013, value driven on InstrF when empty or flushed (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
PCF  in  ADDR_W  fetch address from the PC generator
FlushF  in  1  redirect (PCSrcE); the in-flight fetch is stale
StallD  in  1  decode stage stalled; do not overwrite InstrF
InstrF  out  DATA_W  instruction to IF/ID, registered
InstrValidF  out  1  InstrF holds a real fetched instruction, registered
FetchStallF  out  1  combinational; OR-ed into the PC generator's StallF
mem_req  out  1  memory request, registered
mem_addr  out  ADDR_W  request address, registered
mem_ack  in  1  memory response valid, single-cycle pulse
mem_rdata  in  DATA_W  response data, valid with mem_ack

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - mem_req=0, mem_addr=0, InstrF=NOP_INSTR, InstrValidF=0, skid cleared.
- FSM states: IDLE, WAIT, SKID, DISCARD.
- IDLE:
  - If FlushF=0: mem_addr<=PCF, mem_req<=1, go to WAIT.
  - If FlushF=1: no request, stay in IDLE. PCF is stale this cycle.
- WAIT:
  - mem_req and mem_addr are held until mem_ack.
  - On mem_ack: mem_req<=0.
    - StallD=0: InstrF<=mem_rdata, InstrValidF<=1, go to IDLE.
    - StallD=1: skid<=mem_rdata, go to SKID.
  - FlushF=1 without mem_ack: go to DISCARD.
  - FlushF=1 with mem_ack: drop the data, mem_req<=0, go to IDLE.
- SKID:
  - InstrF is held.
  - When StallD=0: InstrF<=skid, InstrValidF<=1, go to IDLE.
  - FlushF=1: drop skid, go to IDLE.
- DISCARD:
  - mem_req is held until mem_ack.
  - On mem_ack: drop the data, mem_req<=0, go to IDLE.
  - FlushF is ignored (the redirect is already taken).
- FetchStallF = !FlushF && (IDLE || SKID || DISCARD || (WAIT && !mem_ack)).
  - The PC advances only on the edge where the response is accepted.
  - FlushF forces 0 so the redirect target loads.
- Any cycle with FlushF=1: InstrF<=NOP_INSTR, InstrValidF<=0. Flush beats StallD.
- Any accepted cycle with StallD=1 and no flush: InstrF and InstrValidF are held.
- Otherwise, in a cycle with StallD=0 and no new instruction: InstrValidF<=0, InstrF<=NOP_INSTR.
- Latency and throughput:
  - mem_req rises 1 cycle after entering IDLE.
  - Earliest mem_ack is the cycle after mem_req=1.
  - Best case is one instruction per 2 cycles.
- Memory protocol:
  - mem_addr is stable while mem_req=1.
  - mem_ack while mem_req=0 is ignored, including a late response after reset.
- No address arithmetic; PCF is passed through unmodified. Width is ADDR_W.

Test Plan:
- Reset, zero-wait memory (ack 1 cycle after req), PCF=0,4,8 -> mem_addr 0,4,8. InstrF = rdata per fetch, InstrValidF=1 every other cycle. FetchStallF=0 only in ack cycles.
- 3-cycle memory latency at PCF=0x10 -> FetchStallF=1 for 3 cycles, mem_req/mem_addr=0x10 held. InstrF=rdata on the cycle after ack.
- FlushF=1 in WAIT at cycle 1 of 3-cycle latency, PCF then 0x40 -> FetchStallF=0 in the flush cycle, state DISCARD. First response is dropped, InstrValidF=0. Next request has mem_addr=0x40.
- StallD=1 at ack with rdata=0xDEAD, held 2 cycles -> InstrF unchanged and FetchStallF=1 during SKID. InstrF=0xDEAD the cycle after StallD falls.
- FlushF and StallD both 1 in SKID -> skid dropped, InstrF=NOP_INSTR, InstrValidF=0, state IDLE.
- rst asserted mid-WAIT, then stray mem_ack after release -> all outputs at reset values. Stray ack is ignored. A new request is issued with mem_addr=PCF.
